eof_error_block: RTL and testbench



---
 rtl/eof_error_block_if.sv | 19 +
 rtl/eof_error_block.sv | 83 ++++++++
 tb/tb_eof_error_block.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/eof_error_block_if.sv
// Bus bundle between the CAN frame decoder and the EOF form checker.
// The master drives the sampled bus level and the EOF start flag; the slave returns the EOF form error.
interface eof_error_block_if;
    logic RX;
    logic EOF_Flag;
    logic EOF_Error;

    modport master (
        output RX,
        output EOF_Flag,
        input  EOF_Error
    );

    modport slave (
        input  RX,
        input  EOF_Flag,
        output EOF_Error
    );
endinterface

// File: rtl/eof_error_block.sv
// CAN receiver End-of-Frame form checker: the EOF_LEN bits after EOF_Flag must all be recessive.
// Optional macro EOF_LAST_BIT_DONTCARE_EN: a dominant last EOF bit is tolerated (CAN receiver rule).
module eof_error_block #(
    parameter int EOF_LEN = 7,
    parameter int CNT_W   = 4
) (
    input  logic              SP,
    input  logic              reset,
    eof_error_block_if.slave  eof_bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        CHECK = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(EOF_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic             r_eof_error;

    logic             w_last_bit;
    logic             w_dominant_ok;
    logic [CNT_W-1:0] w_count_inc;

    // Current bit is the final EOF bit when count+1 == EOF_LEN.
    assign w_last_bit  = (r_count == LAST_IDX);
    assign w_count_inc = (r_count == CNT_MAX) ? r_count : (r_count + {{(CNT_W-1){1'b0}}, 1'b1});

`ifdef EOF_LAST_BIT_DONTCARE_EN
    assign w_dominant_ok = w_last_bit;
`else
    assign w_dominant_ok = 1'b0;
`endif

    assign eof_bus.EOF_Error = r_eof_error;

    // EOF check FSM: EOF_Flag restarts the window and has priority over the RX check.
    always_ff @(posedge SP or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_count     <= {CNT_W{1'b0}};
            r_eof_error <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (eof_bus.EOF_Flag) begin
                        r_state     <= CHECK;
                        r_count     <= {CNT_W{1'b0}};
                        r_eof_error <= 1'b0;
                    end else begin
                        r_state     <= IDLE;
                        r_count     <= r_count;
                        r_eof_error <= r_eof_error;
                    end
                end
                CHECK: begin
                    if (eof_bus.EOF_Flag) begin
                        r_state     <= CHECK;
                        r_count     <= {CNT_W{1'b0}};
                        r_eof_error <= 1'b0;
                    end else if (!eof_bus.RX && !w_dominant_ok) begin
                        r_state     <= IDLE;
                        r_count     <= r_count;
                        r_eof_error <= 1'b1;
                    end else begin
                        r_state     <= w_last_bit ? IDLE : CHECK;
                        r_count     <= w_count_inc;
                        r_eof_error <= r_eof_error;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_count     <= {CNT_W{1'b0}};
                    r_eof_error <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eof_error_block.sv
// Directed self-checking bench for eof_error_block with EOF_LEN = 7.
// Expected values are hand-derived from the EOF check rules.
module tb_eof_error_block;

    logic SP;
    logic reset;
    int   n_checks;
    int   n_fail;
    logic exp_last;

    eof_error_block_if bus ();

    eof_error_block #(
        .EOF_LEN (7),
        .CNT_W   (4)
    ) dut (
        .SP      (SP),
        .reset   (reset),
        .eof_bus (bus.slave)
    );

    initial SP = 1'b0;
    always #5 SP = ~SP;

    // One sample point; outputs are read 1 time unit after the rising edge.
    task automatic tick();
        @(posedge SP);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.RX = 1'b1;
        bus.EOF_Flag = 1'b0;
        #2;
        n_checks++;
        if (bus.EOF_Error !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_value: got %b expected 0", bus.EOF_Error);
        end
        // A flag seen while in reset must not start a check.
        bus.EOF_Flag = 1'b1;
        tick();
        bus.EOF_Flag = 1'b0;
        reset = 1'b1;
        bus.RX = 1'b0;
        tick();
        n_checks++;
        if (bus.EOF_Error !== 1'b0) begin
            n_fail++;
            $display("FAIL flag_in_reset: got %b expected 0", bus.EOF_Error);
        end
    endtask

    task automatic test_good_frame();
        bus.EOF_Flag = 1'b1;
        bus.RX = 1'b0;
        tick();
        bus.EOF_Flag = 1'b0;
        n_checks++;
        if (bus.EOF_Error !== 1'b0) begin
            n_fail++;
            $display("FAIL good_flag_edge: got %b expected 0", bus.EOF_Error);
        end
        bus.RX = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            n_checks++;
            if (bus.EOF_Error !== 1'b0) begin
                n_fail++;
                $display("FAIL good_bit%0d: got %b expected 0", i + 1, bus.EOF_Error);
            end
        end
        // Window closed: dominant bits now fall in IDLE and are ignored.
        bus.RX = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (bus.EOF_Error !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_after_window%0d: got %b expected 0", i, bus.EOF_Error);
            end
        end
    endtask

    task automatic test_dominant_bit3();
        logic [2:0] bits;
        bits = 3'b011;
        bus.EOF_Flag = 1'b1;
        tick();
        bus.EOF_Flag = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.RX = bits[i];
            tick();
            n_checks++;
            if (bus.EOF_Error !== (i == 2)) begin
                n_fail++;
                $display("FAIL dom_bit%0d: got %b expected %b", i + 1, bus.EOF_Error, (i == 2));
            end
        end
        for (int i = 0; i < 10; i++) begin
            bus.RX = i[0];
            tick();
            n_checks++;
            if (bus.EOF_Error !== 1'b1) begin
                n_fail++;
                $display("FAIL dom_sticky%0d: got %b expected 1", i, bus.EOF_Error);
            end
        end
    endtask

    task automatic test_clear_on_flag();
        bus.EOF_Flag = 1'b1;
        bus.RX = 1'b0;
        tick();
        bus.EOF_Flag = 1'b0;
        n_checks++;
        if (bus.EOF_Error !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_flag_edge: got %b expected 0", bus.EOF_Error);
        end
        bus.RX = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            n_checks++;
            if (bus.EOF_Error !== 1'b0) begin
                n_fail++;
                $display("FAIL clear_bit%0d: got %b expected 0", i + 1, bus.EOF_Error);
            end
        end
    endtask

    task automatic test_last_bit();
`ifdef EOF_LAST_BIT_DONTCARE_EN
        exp_last = 1'b0;
`else
        exp_last = 1'b1;
`endif
        bus.EOF_Flag = 1'b1;
        tick();
        bus.EOF_Flag = 1'b0;
        bus.RX = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        n_checks++;
        if (bus.EOF_Error !== 1'b0) begin
            n_fail++;
            $display("FAIL last_bit6: got %b expected 0", bus.EOF_Error);
        end
        bus.RX = 1'b0;
        tick();
        n_checks++;
        if (bus.EOF_Error !== exp_last) begin
            n_fail++;
            $display("FAIL last_bit7: got %b expected %b", bus.EOF_Error, exp_last);
        end
        tick();
        n_checks++;
        if (bus.EOF_Error !== exp_last) begin
            n_fail++;
            $display("FAIL last_bit_idle: got %b expected %b", bus.EOF_Error, exp_last);
        end
    endtask

    task automatic test_restart();
        // Restart then seven recessive bits: no error.
        bus.EOF_Flag = 1'b1;
        tick();
        bus.EOF_Flag = 1'b0;
        bus.RX = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        bus.EOF_Flag = 1'b1;
        bus.RX = 1'b0;
        tick();
        bus.EOF_Flag = 1'b0;
        n_checks++;
        if (bus.EOF_Error !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_flag_priority: got %b expected 0", bus.EOF_Error);
        end
        bus.RX = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        n_checks++;
        if (bus.EOF_Error !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_clean: got %b expected 0", bus.EOF_Error);
        end
        // Restart then dominant on bit 6: only caught if the count restarted.
        bus.EOF_Flag = 1'b1;
        tick();
        bus.EOF_Flag = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        bus.EOF_Flag = 1'b1;
        tick();
        bus.EOF_Flag = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        bus.RX = 1'b0;
        tick();
        n_checks++;
        if (bus.EOF_Error !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_bit6_dom: got %b expected 1", bus.EOF_Error);
        end
    endtask

    task automatic test_async_reset();
        // Error is latched from the previous test; reset between edges.
        @(negedge SP);
        reset = 1'b0;
        #1;
        n_checks++;
        if (bus.EOF_Error !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got %b expected 0", bus.EOF_Error);
        end
        #2;
        reset = 1'b1;
        bus.RX = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (bus.EOF_Error !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_rx_dom%0d: got %b expected 0", i, bus.EOF_Error);
            end
        end
        // Reset mid-check aborts the window without an error.
        bus.EOF_Flag = 1'b1;
        bus.RX = 1'b1;
        tick();
        bus.EOF_Flag = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #2;
        reset = 1'b1;
        bus.RX = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        n_checks++;
        if (bus.EOF_Error !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_check: got %b expected 0", bus.EOF_Error);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_good_frame();
        test_dominant_bit3();
        test_clear_on_flag();
        test_last_bit();
        test_restart();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
